// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_unit
//  Description : MEM-stage data memory and stack responder. Services
//                load/store, PUSH/POP and CALL/RET requests against an
//                internal word array, owns the stack pointer and returns a
//                one-cycle completion pulse with registered read data.
//                Optional build macro STACK_GUARD_EN enables depth checking
//                with sticky overflow/underflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2,
    parameter int STACK_DEPTH  = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable_data_memory_write,
    input  logic                  enable_data_memory_read,
    input  logic [1:0]            stack_value,
    input  logic                  DataT,
    input  logic [ADDR_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] return_address,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_done,
    output logic [ADDR_WIDTH-1:0] stack_pointer,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    // Counter only has to hold READ_LATENCY-1; keep at least one bit.
    localparam int CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int WORDS   = 1 << ADDR_WIDTH;

    localparam logic [CNT_W-1:0]      CNT_READ_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE       = CNT_W'(1);
    localparam logic [DEPTH_W-1:0]    DEPTH_ONE     = DEPTH_W'(1);
    localparam logic [ADDR_WIDTH-1:0] SP_ONE        = ADDR_WIDTH'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] OP_STORE = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_PUSH  = 2'd2;
    localparam logic [1:0] OP_POP   = 2'd3;

    localparam logic [1:0] SV_PUSH = 2'b01;
    localparam logic [1:0] SV_POP  = 2'b10;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] sp;
    logic [DEPTH_W-1:0]    depth;
    logic                  req_d;

    logic                  req;
    logic                  trigger;
    logic                  commit;
    logic [1:0]            op_next;
    logic [ADDR_WIDTH-1:0] sp_dec;
    logic                  push_blocked;
    logic                  pop_blocked;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;

    assign req     = enable_data_memory_write | enable_data_memory_read;
    assign trigger = (state == IDLE) && req && !req_d;
    assign commit  = (state == ACCESS) && (cnt == '0);
    assign sp_dec  = sp - SP_ONE;

    // Decode the request at capture time; write has priority over read.
    always_comb begin
        op_next = OP_LOAD;
        if (enable_data_memory_write) begin
            op_next = (stack_value == SV_PUSH) ? OP_PUSH : OP_STORE;
        end else if (stack_value == SV_POP) begin
            op_next = OP_POP;
        end
    end

`ifdef STACK_GUARD_EN
    assign push_blocked = (depth == DEPTH_W'(STACK_DEPTH));
    assign pop_blocked  = (depth == '0);
`else
    assign push_blocked = 1'b0;
    assign pop_blocked  = 1'b0;
`endif

    assign mem_we    = commit && ((op == OP_STORE) || ((op == OP_PUSH) && !push_blocked));
    assign mem_waddr = (op == OP_PUSH) ? sp_dec : addr;

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= wdata;
        end
    end

    // Request edge detect, access FSM, stack pointer/depth and read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_d     <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            op        <= OP_STORE;
            addr      <= '0;
            wdata     <= '0;
            sp        <= '0;
            depth     <= '0;
            read_data <= '0;
        end else begin
            req_d <= req;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        op    <= op_next;
                        addr  <= alu_result;
                        wdata <= DataT ? return_address : store_data;
                        cnt   <= enable_data_memory_write ? '0 : CNT_READ_INIT;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state <= DONE;
                        case (op)
                            OP_PUSH: begin
                                if (!push_blocked) begin
                                    sp    <= sp_dec;
                                    depth <= depth + DEPTH_ONE;
                                end
                            end
                            OP_POP: begin
                                if (pop_blocked) begin
                                    read_data <= '0;
                                end else begin
                                    read_data <= mem[sp];
                                    sp        <= sp + SP_ONE;
                                    depth     <= depth - DEPTH_ONE;
                                end
                            end
                            OP_LOAD: begin
                                read_data <= mem[addr];
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STACK_GUARD_EN
    logic ovf_flag;
    logic unf_flag;

    // Sticky guard flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else if (commit) begin
            if ((op == OP_PUSH) && push_blocked) begin
                ovf_flag <= 1'b1;
            end
            if ((op == OP_POP) && pop_blocked) begin
                unf_flag <= 1'b1;
            end
        end
    end

    assign stack_overflow  = ovf_flag;
    assign stack_underflow = unf_flag;
`else
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;
`endif

    assign mem_done      = (state == DONE);
    assign stack_pointer = sp;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_unit
//  Description : Self-checking bench for data_memory_unit. Random and directed
//                requests are compared with a transaction-level model of the
//                memory array and stack. Honours STACK_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_unit;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RL = 2;
`ifdef STACK_GUARD_EN
    localparam int SD    = 2;
    localparam bit GUARD = 1'b1;
`else
    localparam int SD    = 64;
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr, rd, dt;
    logic [1:0]    sv;
    logic [AW-1:0] alu;
    logic [DW-1:0] sdata, raddr;
    logic [DW-1:0] read_data;
    logic          mem_done;
    logic [AW-1:0] stack_pointer;
    logic          stack_overflow, stack_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] mmem [1 << AW];
    logic [AW-1:0] m_sp;
    int            m_depth;
    logic [DW-1:0] m_rd;
    bit            m_ovf, m_unf;

    data_memory_unit #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL),
        .STACK_DEPTH (SD)
    ) dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .enable_data_memory_write(wr),
        .enable_data_memory_read (rd),
        .stack_value             (sv),
        .DataT                   (dt),
        .alu_result              (alu),
        .store_data              (sdata),
        .return_address          (raddr),
        .read_data               (read_data),
        .mem_done                (mem_done),
        .stack_pointer           (stack_pointer),
        .stack_overflow          (stack_overflow),
        .stack_underflow         (stack_underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sp = '0; m_depth = 0; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_push(input logic [DW-1:0] data);
        if (GUARD && m_depth == SD) begin
            m_ovf = 1'b1;
        end else begin
            m_sp = m_sp - 1'b1;
            mmem[m_sp] = data;
            m_depth++;
        end
    endtask

    task automatic model_pop();
        if (GUARD && m_depth == 0) begin
            m_unf = 1'b1;
            m_rd  = '0;
        end else begin
            m_rd = mmem[m_sp];
            m_sp = m_sp + 1'b1;
            m_depth--;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".read_data"}, read_data, m_rd);
        check({tag, ".sp"}, stack_pointer, m_sp);
        check({tag, ".overflow"}, stack_overflow, m_ovf);
        check({tag, ".underflow"}, stack_underflow, m_unf);
    endtask

    // One request held for 'hold' edges; inputs other than the request lines
    // are scrambled right after the trigger edge to prove they were captured.
    task automatic xact(input bit w, input bit r, input logic [1:0] s, input bit d,
                        input logic [AW-1:0] a, input logic [DW-1:0] sd_i,
                        input logic [DW-1:0] ra_i, input int hold);
        int lat, total, done_cnt, first;
        logic [DW-1:0] data;
        data = d ? ra_i : sd_i;
        if (w) begin
            lat = 1;
            if (s == 2'b01) model_push(data);
            else            mmem[a] = data;
        end else begin
            lat = RL;
            if (s == 2'b10) model_pop();
            else            m_rd = mmem[a];
        end
        wr = w; rd = r; sv = s; dt = d; alu = a; sdata = sd_i; raddr = ra_i;
        total = (hold > lat + 2) ? hold : lat + 2;
        done_cnt = 0;
        first = -1;
        for (int k = 0; k < total; k++) begin
            @(posedge clock);
            if (k == 0) begin
                #1;
                alu = AW'($urandom); sdata = DW'($urandom); raddr = DW'($urandom);
                dt = 1'($urandom); sv = 2'($urandom);
            end
            @(negedge clock);
            if (mem_done) begin
                done_cnt++;
                if (first < 0) first = k;
            end
            if (k == hold - 1) begin
                wr = 1'b0; rd = 1'b0;
            end
        end
        wr = 1'b0; rd = 1'b0;
        @(posedge clock);
        @(negedge clock);
        if (mem_done) done_cnt++;
        check("done_count", done_cnt, 1);
        check("done_latency", first, lat);
        check_state("xact");
    endtask

    // Reset asserted one time unit after the trigger edge of a request.
    task automatic reset_mid(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int done_cnt;
        wr = w; rd = !w; sv = 2'b00; dt = 1'b0; alu = a; sdata = d;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        wr = 1'b0; rd = 1'b0;
        model_reset();
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (mem_done) done_cnt++;
        end
        check("reset_done_count", done_cnt, 0);
        check_state("reset_mid");
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        wr = 1'b0; rd = 1'b0; sv = 2'b00; dt = 1'b0;
        alu = '0; sdata = '0; raddr = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset.mem_done", mem_done, 1'b0);
        check_state("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Fill the whole array so every later read has a known value.
        for (int a = 0; a < (1 << AW); a++) begin
            xact(1'b1, 1'b0, 2'b00, 1'b0, AW'(a), DW'($urandom), '0, 1);
        end

        // Store held five cycles, then load it back.
        xact(1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 16'hBEEF, '0, 5);
        xact(1'b0, 1'b1, 2'b00, 1'b0, 8'h10, '0, '0, 2);
        check("lw_beef", read_data, 16'hBEEF);

        // PUSH, PUSH, POP, POP.
        xact(1'b1, 1'b0, 2'b01, 1'b0, '0, 16'h1111, '0, 1);
        check("push1_sp", stack_pointer, 8'hFF);
        xact(1'b1, 1'b0, 2'b01, 1'b0, '0, 16'h2222, '0, 2);
        check("push2_sp", stack_pointer, 8'hFE);
        xact(1'b0, 1'b1, 2'b10, 1'b0, '0, '0, '0, 1);
        check("pop_data", read_data, 16'h2222);
        check("pop_sp", stack_pointer, 8'hFF);
        xact(1'b0, 1'b1, 2'b10, 1'b0, '0, '0, '0, 3);
        check("pop2_data", read_data, 16'h1111);

        // CALL then RET.
        xact(1'b1, 1'b0, 2'b01, 1'b1, '0, 16'h9999, 16'h0042, 2);
        check("call_sp", stack_pointer, 8'hFF);
        xact(1'b0, 1'b1, 2'b10, 1'b0, '0, '0, '0, 1);
        check("ret_data", read_data, 16'h0042);
        check("ret_sp", stack_pointer, 8'h00);

        // Write and read together: the store wins.
        xact(1'b1, 1'b1, 2'b00, 1'b0, 8'h20, 16'h1234, '0, 3);
        check("combo_rd_kept", read_data, 16'h0042);
        xact(1'b0, 1'b1, 2'b00, 1'b0, 8'h20, '0, '0, 1);
        check("combo_load", read_data, 16'h1234);

`ifdef STACK_GUARD_EN
        xact(1'b1, 1'b0, 2'b01, 1'b0, '0, 16'hA001, '0, 1);
        xact(1'b1, 1'b0, 2'b01, 1'b0, '0, 16'hA002, '0, 1);
        xact(1'b1, 1'b0, 2'b01, 1'b0, '0, 16'hA003, '0, 1);
        check("guard_ovf", stack_overflow, 1'b1);
        check("guard_ovf_sp", stack_pointer, 8'hFE);
        xact(1'b0, 1'b1, 2'b10, 1'b0, '0, '0, '0, 1);
        check("guard_pop_top", read_data, 16'hA002);
        xact(1'b0, 1'b1, 2'b10, 1'b0, '0, '0, '0, 1);
        xact(1'b0, 1'b1, 2'b10, 1'b0, '0, '0, '0, 1);
        check("guard_unf", stack_underflow, 1'b1);
        check("guard_unf_rd", read_data, 16'h0000);
        check("guard_unf_sp", stack_pointer, 8'h00);
`endif

        // Reset in the middle of a load and of a not-yet-committed store.
        reset_mid(1'b0, 8'h10, '0);
        xact(1'b0, 1'b1, 2'b00, 1'b0, 8'h10, '0, '0, 1);
        check("after_reset_load", read_data, 16'hBEEF);
        reset_mid(1'b1, 8'h20, 16'h5A5A);
        xact(1'b0, 1'b1, 2'b00, 1'b0, 8'h20, '0, '0, 1);
        check("write_not_committed", read_data, 16'h1234);

        // Random mix of every operation type.
        for (int i = 0; i < 200; i++) begin
            bit w, r;
            int sel;
            sel = $urandom_range(0, 2);
            w = (sel != 1);
            r = (sel != 0);
            xact(w, r, 2'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
                 DW'($urandom), $urandom_range(1, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_unit.md
# data_memory_unit

Data-memory and stack responder for the multi-cycle processor. It sits on the datapath side of the control unit's MEM stage and services its request signals: `enable_data_memory_write`, `enable_data_memory_read`, `stack_value` and `DataT`. It performs load/store, PUSH/POP and CALL/RET accesses against an internal word array, owns the stack pointer, and returns a one-cycle completion pulse with registered read data.

## Interface
- ADDR_WIDTH, 8, word-address width; array holds 2^ADDR_WIDTH words
- DATA_WIDTH, 16, word width
- READ_LATENCY, 2, edges spent in ACCESS for a read (≥1); writes always take 1
- STACK_DEPTH, 64, maximum stack entries (≤ 2^ADDR_WIDTH); stack occupies the top STACK_DEPTH words
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable_data_memory_write  in  1  write request (level; may be held many cycles)
- enable_data_memory_read  in  1  read request (level; may be held many cycles)
- stack_value  in  2  2'b00 OTHER, 2'b01 PUSH, 2'b10 POP, 2'b11 treated as OTHER
- DataT  in  1  1: write data = return_address (CALL); 0: write data = store_data
- alu_result  in  ADDR_WIDTH  effective address for load/store
- store_data  in  DATA_WIDTH  register data for SW/PUSH
- return_address  in  DATA_WIDTH  PC+1 for CALL
- read_data  out  DATA_WIDTH  registered result of last completed read
- mem_done  out  1  one-cycle completion pulse
- stack_pointer  out  ADDR_WIDTH  current SP (points at top-of-stack entry)
- stack_overflow  out  1  sticky: PUSH attempted while full
- stack_underflow  out  1  sticky: POP attempted while empty

## Operation
- Request `req` = write | read. `req_d` = `req` registered. A new access starts only on an edge in IDLE where `req`=1 and `req_d`=0; a held level never retriggers.
- Decoded at capture:
  - write & PUSH → push
  - write & OTHER/POP → store at alu_result
  - read & POP → pop
  - read & other → load at alu_result
  - write and read both high: write wins; read ignored.
- Captured into internal registers: operation, address and write data (return_address if DataT else store_data). Later input changes are ignored until IDLE.
- Push (pre-decrement): SP ← SP−1 mod 2^ADDR_WIDTH, then mem[new SP] ← data, and depth +1.
- Pop (post-increment): read_data ← mem[SP], SP ← SP+1 mod 2^ADDR_WIDTH, and depth −1.
- Store: mem[addr] ← data; read_data unchanged. Load: read_data ← mem[addr].
- FSM states: IDLE, ACCESS, DONE.
  - IDLE→ACCESS on trigger; counter loads READ_LATENCY−1 for reads, 0 for writes.
  - ACCESS decrements the counter each edge. At 0 it performs the access, updates SP, depth and read_data, and goes to DONE.
  - DONE→IDLE unconditionally. mem_done = (state == DONE).
- Reset values: SP 0 (empty stack), depth 0, read_data 0, mem_done 0, both flags 0, state IDLE, req_d 0. Array contents are not reset.

## Timing
- Trigger edge E0 (IDLE, req=1, req_d=0) enters ACCESS.
- Write: committed at E1; mem_done high E1→E2.
- Read: data valid and mem_done high from E(READ_LATENCY) for one cycle; read_data holds until the next read completes.
- Minimum back-to-back spacing: requests must drop low for ≥1 edge before a new trigger. A request still held after DONE is ignored.
- Reset asserted mid-access: immediate return to reset values. An in-flight write is not committed if it had not yet reached its commit edge.
- SP wrap: push at SP=0 gives SP=2^ADDR_WIDTH−1.

## Configuration
- `STACK_GUARD_EN` defined:
  - push with depth==STACK_DEPTH sets stack_overflow, skips the write, leaves SP unchanged, and still pulses mem_done;
  - pop with depth==0 sets stack_underflow, returns read_data=0, leaves SP unchanged, and pulses mem_done;
  - flags clear only on reset.
- Undefined: no depth check; SP wraps modulo 2^ADDR_WIDTH; both flags tied to 0.

## Test plan
- Store/load: SW alu_result=8'h10, data 16'hBEEF, held 5 cycles → one mem_done at E1, no retrigger; then LW 8'h10 → mem_done at E2 with read_data=16'hBEEF.
- PUSH 16'h1111 then PUSH 16'h2222 → SP 8'hFF then 8'hFE; POP → read_data=16'h2222, SP=8'hFF.
- CALL: write, PUSH, DataT=1, return_address=16'h0042, store_data=16'h9999 → mem[8'hFF]=16'h0042; RET (read, POP) → read_data=16'h0042, SP=0.
- Guard (macro defined, STACK_DEPTH=2): 3 PUSHes → third sets stack_overflow=1 and SP stays 8'hFE; from empty, POP → stack_underflow=1 and read_data=0.
- Write and read together with OTHER → store happens; read_data unchanged; single mem_done.
- reset_n low at E0+1 of a READ_LATENCY=2 load → mem_done never pulses, read_data=0, state IDLE; the next trigger after release works normally.
